// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single-port synchronous data RAM between the Hack CPU data port
// and the screen scanout reader. CPU normally has priority; a saturating wait
// counter lets the video reader take the next slot once it has waited
// VID_DEADLINE cycles while losing to the CPU, so scanout cannot starve.
//
// Optional feature macro: MEMARB_PERF_EN
//   When defined, adds cpu_wait_cnt, a 16-bit saturating count of cycles in
//   which cpu_stall was high. Arbitration and timing are unchanged.
//
// Ports
//   clk, reset            system clock (rising edge), synchronous active-high reset
//   cpu_req/we/addr/wdata CPU request; we/addr/wdata sampled at grant
//   cpu_rdata, cpu_ack    read data (valid in ack cycle of a read), 1-cycle ack
//   cpu_stall             cpu_req & ~cpu_ack (combinational)
//   vid_req/addr          scanout read request; addr sampled at grant
//   vid_rdata, vid_valid  scanout data, 1-cycle valid pulse
//   mem_addr/we/wdata     registered RAM controls
//   mem_rdata             RAM read data, one cycle after the address edge
//   cpu_wait_cnt          stall-cycle counter (MEMARB_PERF_EN only)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int VID_DEADLINE = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [14:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_stall,
    input  logic        vid_req,
    input  logic [14:0] vid_addr,
    output logic [15:0] vid_rdata,
    output logic        vid_valid,
    output logic [14:0] mem_addr,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
`ifdef MEMARB_PERF_EN
    output logic [15:0] cpu_wait_cnt,
`endif
    input  logic [15:0] mem_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CPU_ACC,
        ST_CPU_DATA,
        ST_VID_ACC,
        ST_VID_DATA
    } state_t;

    localparam logic [3:0] DEADLINE = 4'(VID_DEADLINE);

    state_t      r_state;
    logic        r_cpu_we;
    logic [14:0] r_mem_addr;
    logic        r_mem_we;
    logic [15:0] r_mem_wdata;
    logic        r_cpu_ack;
    logic        r_vid_valid;
    logic [15:0] r_cpu_rdata;
    logic [15:0] r_vid_rdata;
    logic [3:0]  r_wait_cnt;

    logic w_vid_win;
    logic w_vid_grant;

    // Video wins when it is alone, or when it has waited long enough.
    assign w_vid_win   = vid_req & (~cpu_req | (r_wait_cnt >= DEADLINE));
    assign w_vid_grant = (r_state == ST_IDLE) & w_vid_win;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cpu_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_cpu_ack   <= 1'b0;
            r_vid_valid <= 1'b0;
            r_cpu_rdata <= '0;
            r_vid_rdata <= '0;
            r_wait_cnt  <= '0;
        end else begin
            r_cpu_ack   <= 1'b0;
            r_vid_valid <= 1'b0;

            // Wait counter: cleared on the video grant edge, otherwise counts
            // (saturating) any cycle video is asking but not being granted.
            if (w_vid_grant) begin
                r_wait_cnt <= '0;
            end else if (vid_req && (r_wait_cnt < DEADLINE)) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_vid_win) begin
                        r_state    <= ST_VID_ACC;
                        r_mem_addr <= vid_addr;
                        r_mem_we   <= 1'b0;
                    end else if (cpu_req) begin
                        r_state     <= ST_CPU_ACC;
                        r_mem_addr  <= cpu_addr;
                        r_mem_wdata <= cpu_wdata;
                        r_mem_we    <= cpu_we;
                        r_cpu_we    <= cpu_we;
                        // A write completes in the access cycle itself.
                        r_cpu_ack   <= cpu_we;
                    end
                end
                ST_CPU_ACC: begin
                    r_mem_we <= 1'b0;
                    if (r_cpu_we) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state   <= ST_CPU_DATA;
                        r_cpu_ack <= 1'b1;
                    end
                end
                ST_CPU_DATA: begin
                    r_cpu_rdata <= mem_rdata;
                    r_state     <= ST_IDLE;
                end
                ST_VID_ACC: begin
                    r_state     <= ST_VID_DATA;
                    r_vid_valid <= 1'b1;
                end
                ST_VID_DATA: begin
                    r_vid_rdata <= mem_rdata;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Read data passes straight through in the data cycle and is held by the
    // capture register afterwards.
    assign cpu_rdata = (r_state == ST_CPU_DATA) ? mem_rdata : r_cpu_rdata;
    assign vid_rdata = (r_state == ST_VID_DATA) ? mem_rdata : r_vid_rdata;

    assign cpu_ack   = r_cpu_ack;
    assign vid_valid = r_vid_valid;
    assign cpu_stall = cpu_req & ~r_cpu_ack;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;

`ifdef MEMARB_PERF_EN
    logic [15:0] r_perf_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_cnt <= '0;
        end else if (cpu_stall && (r_perf_cnt != 16'hFFFF)) begin
            r_perf_cnt <= r_perf_cnt + 16'd1;
        end
    end

    assign cpu_wait_cnt = r_perf_cnt;
`endif

endmodule
